// File: rtl/reg_dump_reader.sv
// Walks register addresses 0..DEPTH-1 and presents each word. Each word takes 3 cycles (issue, capture, present) plus any stall.
// OUT_DATA/OUT_ADDR are held until OUT_READY. Define REG_DUMP_PARITY_EN to add the OUT_PAR even-parity output.
module reg_dump_reader #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              ABORT,
  output logic              RF_READ,
  output logic [ADDR_W-1:0] RF_ADDR,
  input  logic [DATA_W-1:0] RF_DATA,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [ADDR_W-1:0] OUT_ADDR,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              BUSY,
  output logic              DONE
`ifdef REG_DUMP_PARITY_EN
  ,
  output logic              OUT_PAR
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, PRESENT} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic                done_q, done_d;
`ifdef REG_DUMP_PARITY_EN
  logic                out_par_q, out_par_d;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_addr_q <= '0;
      done_q     <= 1'b0;
`ifdef REG_DUMP_PARITY_EN
      out_par_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_addr_q <= out_addr_d;
      done_q     <= done_d;
`ifdef REG_DUMP_PARITY_EN
      out_par_q  <= out_par_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_addr_d = out_addr_q;
    done_d     = 1'b0;
`ifdef REG_DUMP_PARITY_EN
    out_par_d  = out_par_q;
`endif
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = ISSUE;
          cnt_d   = '0;
        end
      end
      ISSUE:   state_d = CAPTURE;
      CAPTURE: begin
        state_d    = PRESENT;
        out_data_d = RF_DATA;
        out_addr_d = cnt_q;
`ifdef REG_DUMP_PARITY_EN
        out_par_d  = ^RF_DATA;
`endif
      end
      PRESENT: begin
        if (OUT_READY) begin
          if (cnt_q == LAST_ADDR) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ISSUE;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything, including a completion on the last word.
    if (ABORT && state_q != IDLE) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
  end

  assign RF_READ   = (state_q == ISSUE);
  assign RF_ADDR   = cnt_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_ADDR  = out_addr_q;
  assign OUT_VALID = (state_q == PRESENT);
  assign BUSY      = (state_q != IDLE);
  assign DONE      = done_q;
`ifdef REG_DUMP_PARITY_EN
  assign OUT_PAR   = out_par_q;
`endif

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: register-file responder, per-cycle reference model
// checker, directed scenarios and a randomized run.
module tb_reg_dump_reader;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              START = 1'b0;
  logic              ABORT = 1'b0;
  logic              RF_READ;
  logic [ADDR_W-1:0] RF_ADDR;
  logic [DATA_W-1:0] RF_DATA;
  logic [DATA_W-1:0] OUT_DATA;
  logic [ADDR_W-1:0] OUT_ADDR;
  logic              OUT_VALID;
  logic              OUT_READY = 1'b0;
  logic              BUSY;
  logic              DONE;
`ifdef REG_DUMP_PARITY_EN
  logic              OUT_PAR;
`endif

  reg_dump_reader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
    .RF_READ(RF_READ), .RF_ADDR(RF_ADDR), .RF_DATA(RF_DATA),
    .OUT_DATA(OUT_DATA), .OUT_ADDR(OUT_ADDR), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .BUSY(BUSY), .DONE(DONE)
`ifdef REG_DUMP_PARITY_EN
    , .OUT_PAR(OUT_PAR)
`endif
  );

  initial forever #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Register file contents; read data appears the cycle after the strobe,
  // and is random junk otherwise so a mistimed capture shows up.
  logic [DATA_W-1:0] rf [DEPTH];
  logic              rf_rd;
  logic [ADDR_W-1:0] rf_a;

  initial begin
    RF_DATA = '0;
    forever begin
      @(negedge CLK);
      rf_rd = RF_READ;
      rf_a  = RF_ADDR;
      @(posedge CLK);
      #1;
      RF_DATA = rf_rd ? rf[rf_a] : $urandom;
    end
  end

  // Reference model: a scan is "active", sitting at word m_addr, in phase
  // m_ph (0 = issuing read, 1 = capturing, 2 = presenting).
  bit                m_active = 0;
  int                m_addr = 0;
  int                m_ph = 0;
  bit                m_done = 0;
  logic [DATA_W-1:0] m_cap = '0;
  int                cyc = 0;
  int                start_cyc = 0;
  int                last_hs_cyc = 0;
  int                hs_cnt = 0;
  int                done_seen = 0;

  initial begin
    forever begin
      @(negedge CLK);
      cyc++;
      if (RST) begin
        m_active = 0; m_addr = 0; m_ph = 0; m_done = 0;
        check("rst_busy", BUSY, 0);
        check("rst_valid", OUT_VALID, 0);
        check("rst_done", DONE, 0);
        check("rst_rf_read", RF_READ, 0);
        check("rst_rf_addr", RF_ADDR, 0);
        check("rst_out_data", OUT_DATA, 0);
        check("rst_out_addr", OUT_ADDR, 0);
      end else begin
        check("busy", BUSY, m_active);
        check("rf_read", RF_READ, m_active && m_ph == 0);
        if (m_active && m_ph == 0) check("rf_addr", RF_ADDR, m_addr);
        check("out_valid", OUT_VALID, m_active && m_ph == 2);
        if (m_active && m_ph == 2) begin
          check("out_addr", OUT_ADDR, m_addr);
          check("out_data", OUT_DATA, m_cap);
`ifdef REG_DUMP_PARITY_EN
          check("out_par", OUT_PAR, ^m_cap);
`endif
        end
        check("done", DONE, m_done);
        if (DONE) done_seen++;
        if (OUT_VALID && OUT_READY) hs_cnt++;
        m_done = 0;
        if (!m_active) begin
          if (START) begin
            m_active = 1; m_addr = 0; m_ph = 0; start_cyc = cyc;
          end
        end else if (m_ph == 2 && OUT_READY && m_addr == DEPTH - 1) begin
          last_hs_cyc = cyc;
          m_active = 0;
          m_done = !ABORT;
        end else if (ABORT) begin
          m_active = 0;
        end else if (m_ph == 0) begin
          m_ph = 1;
        end else if (m_ph == 1) begin
          m_ph = 2;
          m_cap = rf[m_addr];
        end else if (OUT_READY) begin
          m_addr++;
          m_ph = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  task automatic run_to_done(input string nm);
    for (int k = 0; k < 300 && !DONE; k++) step();
    check({nm, "_done_reached"}, DONE, 1);
    step();
  endtask

  task automatic run_to_present(input int addr);
    for (int k = 0; k < 300 && !(OUT_VALID && OUT_ADDR == addr); k++) step();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rf[i] = i * 32'h11111111;
    repeat (2) step();
    check("reset_busy", BUSY, 0);
    check("reset_out_data", OUT_DATA, 0);
    RST = 1'b0;
    step();

    // Full scan at full rate, with START pulses mid-scan that must be ignored.
    OUT_READY = 1'b1;
    hs_cnt = 0; done_seen = 0;
    pulse_start();
    for (int k = 0; k < 300 && !DONE; k++) begin
      START = (k == 10 || k == 40);
      step();
    end
    START = 1'b0;
    check("t1_done_reached", DONE, 1);
    step();
    check("t1_words", hs_cnt, 32);
    check("t1_done_pulses", done_seen, 1);
    check("t1_cycles", last_hs_cyc - start_cyc, 96);
    check("t1_idle_after", BUSY, 0);

    // Consumer stall of 5 cycles at address 3.
    begin
      int  stall = 0;
      bit  pend = 0;
      hs_cnt = 0;
      OUT_READY = 1'b0;
      pulse_start();
      for (int k = 0; k < 300 && !DONE; k++) begin
        if (pend) begin
          check("t2_resume_read", RF_READ, 1);
          check("t2_resume_addr", RF_ADDR, 4);
          pend = 0;
        end
        if (OUT_VALID && OUT_ADDR == 3 && stall < 5) begin
          check("t2_stall_data", OUT_DATA, 32'h33333333);
          check("t2_stall_addr", OUT_ADDR, 3);
          check("t2_stall_noread", RF_READ, 0);
          stall++;
          OUT_READY = 1'b0;
        end else begin
          if (OUT_VALID && OUT_ADDR == 3) pend = 1;
          OUT_READY = OUT_VALID;
        end
        step();
      end
      check("t2_done_reached", DONE, 1);
      step();
      check("t2_stall_cycles", stall, 5);
      check("t2_words", hs_cnt, 32);
    end

    // Abort while capturing address 7, then restart from 0.
    OUT_READY = 1'b1;
    done_seen = 0;
    pulse_start();
    for (int k = 0; k < 300 && !(RF_READ && RF_ADDR == 7); k++) step();
    check("t3_reach_issue7", RF_ADDR, 7);
    step();
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
    check("t3_busy", BUSY, 0);
    check("t3_valid", OUT_VALID, 0);
    step();
    check("t3_no_done", done_seen, 0);
    pulse_start();
    check("t3_restart_read", RF_READ, 1);
    check("t3_restart_addr", RF_ADDR, 0);
    run_to_done("t3");

    // Reset asserted mid-cycle while presenting address 10.
    pulse_start();
    run_to_present(10);
    check("t4_at_10", OUT_ADDR, 10);
    #1 RST = 1'b1;
    #1;
    check("t4_rst_busy", BUSY, 0);
    check("t4_rst_valid", OUT_VALID, 0);
    check("t4_rst_data", OUT_DATA, 0);
    check("t4_rst_addr", OUT_ADDR, 0);
    check("t4_rst_rf_addr", RF_ADDR, 0);
    @(posedge CLK);
    #2 RST = 1'b0;
    step();
    step();
    check("t4_stays_idle", BUSY, 0);

    // Abort coincident with the final handshake.
    hs_cnt = 0; done_seen = 0;
    pulse_start();
    run_to_present(31);
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
    check("t5_busy", BUSY, 0);
    check("t5_done_now", DONE, 0);
    step();
    check("t5_words", hs_cnt, 32);
    check("t5_no_done", done_seen, 0);

`ifdef REG_DUMP_PARITY_EN
    rf[0] = 32'h00000001;
    rf[1] = 32'h00000003;
    pulse_start();
    run_to_present(0);
    check("par_word0", OUT_PAR, 1);
    run_to_present(1);
    check("par_word1", OUT_PAR, 0);
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
`endif

    // Randomized traffic.
    for (int i = 0; i < DEPTH; i++) rf[i] = $urandom;
    for (int k = 0; k < 3000; k++) begin
      START     = ($urandom_range(7) == 0);
      ABORT     = ($urandom_range(49) == 0);
      OUT_READY = $urandom_range(1);
      step();
    end
    START = 1'b0; ABORT = 1'b0; OUT_READY = 1'b0;
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register word width.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers scanned (addresses 0..DEPTH-1).
REQ-003 SHALL have parameter ADDR_W, default 5, address width (DEPTH <= 2**ADDR_W).
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 START  input  1  begin scan; sampled in IDLE only.
REQ-007 ABORT  input  1  terminate scan.
REQ-008 RF_READ  output  1  register-file read strobe.
REQ-009 RF_ADDR  output  ADDR_W  register-file read address.
REQ-010 RF_DATA  input  DATA_W  register-file read data, valid the cycle after RF_READ.
REQ-011 OUT_DATA  output  DATA_W  captured word to consumer.
REQ-012 OUT_ADDR  output  ADDR_W  address of OUT_DATA.
REQ-013 OUT_VALID  output  1  OUT_DATA/OUT_ADDR valid.
REQ-014 OUT_READY  input  1  consumer accepts word.
REQ-015 BUSY  output  1  high in any state other than IDLE.
REQ-016 DONE  output  1  one-cycle pulse after last word accepted.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, CAPTURE, PRESENT.
REQ-018 IDLE: START=1 -> ISSUE, address counter := 0; START=0 -> stay.
REQ-019 ISSUE: RF_READ=1, RF_ADDR=counter for exactly one cycle -> CAPTURE; RF_READ=0 in all other states.
REQ-020 CAPTURE: OUT_DATA := RF_DATA, OUT_ADDR := counter -> PRESENT.
REQ-021 PRESENT: OUT_VALID=1; OUT_DATA/OUT_ADDR SHALL hold stable until OUT_VALID&OUT_READY.
REQ-022 PRESENT, handshake, counter<DEPTH-1: counter+1 -> ISSUE; counter=DEPTH-1: -> IDLE, DONE=1 next cycle for one cycle.
REQ-023 Minimum 3 cycles per word (ISSUE, CAPTURE, PRESENT with OUT_READY=1); OUT_VALID deasserts the cycle after handshake.
REQ-024 START while BUSY SHALL be ignored; START in the DONE cycle SHALL begin a new scan.
REQ-025 ABORT=1 in non-IDLE state -> IDLE next cycle, OUT_VALID=0, no DONE; ABORT in IDLE ignored.
REQ-026 ABORT and handshake same cycle: word counts as accepted, abort wins, no DONE even on last address.
REQ-027 Counter SHALL never exceed DEPTH-1; no wrap to 0 within a scan.
REQ-028 OUT_READY outside PRESENT SHALL have no effect.

Reset
REQ-029 RST=1 SHALL immediately force IDLE, counter=0, RF_READ=0, RF_ADDR=0, OUT_DATA=0, OUT_ADDR=0, OUT_VALID=0, BUSY=0, DONE=0, independent of CLK.
REQ-030 RST mid-scan SHALL discard the scan; after RST release a new START is required.

Configuration
REQ-031 Macro REG_DUMP_PARITY_EN defined: output OUT_PAR (1 bit) SHALL exist, captured with OUT_DATA in CAPTURE, value = XOR of all OUT_DATA bits (even parity over data+parity), reset 0, held stable with OUT_DATA.
REQ-032 Macro undefined: OUT_PAR port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-033 RF preloaded reg[i]=i*0x11111111 (DEPTH=32), START pulse, OUT_READY=1 -> 32 words, OUT_ADDR 0..31 in order, OUT_DATA matches, 96 cycles START-to-last-handshake, one DONE pulse.
REQ-034 OUT_READY held 0 for 5 cycles in PRESENT at address 3 -> OUT_DATA/OUT_ADDR=3 stable, no RF_READ, resumes at address 4 when OUT_READY=1.
REQ-035 ABORT during CAPTURE at address 7 -> IDLE next cycle, BUSY=0, OUT_VALID=0, no DONE; later START restarts at address 0.
REQ-036 RST asserted mid-cycle in PRESENT at address 10 -> all outputs 0 before next CLK edge; START pulses during scan ignored (count stays 32 words).
REQ-037 ABORT coincident with handshake at address 31 -> word accepted, no DONE, IDLE next cycle.
REQ-038 With REG_DUMP_PARITY_EN, reg[0]=0x00000001 -> OUT_PAR=1; reg[1]=0x00000003 -> OUT_PAR=0.
